// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern sequencer.
// FSM state encoding, pixel width and fade depth.
package pattern_pkg;
  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  localparam int RGB_W     = 6;
  localparam int ATTEN_MAX = 2;
  localparam int ATTEN_W   = 2;
endpackage

// File: rtl/pattern_sequencer_rgb_attenuator.sv
// Per-channel right shift of an RRGGBB pixel.
// A shift of 2 or more yields black.
module rgb_attenuator
  import pattern_pkg::*;
(
  input  logic [RGB_W-1:0]   i_px,
  input  logic [ATTEN_W-1:0] i_shift,
  output logic [RGB_W-1:0]   o_px
);

  // shift each 2-bit colour channel independently
  always_comb begin
    o_px = '0;
    for (int c = 0; c < RGB_W / 2; c++) begin
      o_px[2*c +: 2] = i_px[2*c +: 2] >> i_shift;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Sequences N pattern generators with per-pattern dwell,
// manual skip and optional fade-through-black switching.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int FRAME_W      = 10,
  parameter int SEL_W        = $clog2(NUM_PATTERNS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            vsync,
  input  logic                            paused,
  input  logic                            manual,
  input  logic                            fade_en,
  input  logic                            skip_req,
  input  logic [NUM_PATTERNS*FRAME_W-1:0] dwell_frames,
  input  logic [NUM_PATTERNS*RGB_W-1:0]   rgb_in,
  output logic [NUM_PATTERNS-1:0]         next_frame,
  output logic [SEL_W-1:0]                pattern_select,
  output logic                            switch_pulse,
  output logic [RGB_W-1:0]                rgb
);

  state_t               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [FRAME_W-1:0]   r_cnt;
  logic [ATTEN_W-1:0]   r_atten;
  logic                 r_swp;
  logic                 r_skip;
  logic                 r_vsync_q;

  logic                 w_tick;
  logic                 w_expire;
  logic                 w_decide;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [FRAME_W-1:0]   w_dwell;
  logic [FRAME_W-1:0]   w_lim_m1;
  logic [RGB_W-1:0]     w_px;

  assign w_tick = vsync & ~r_vsync_q & ~paused;

  // select the dwell and pixel of the active pattern
  always_comb begin
    w_dwell = '0;
    w_px    = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_dwell = dwell_frames[i*FRAME_W +: FRAME_W];
        w_px    = rgb_in[i*RGB_W +: RGB_W];
      end
    end
  end

  assign w_lim_m1 = (w_dwell == '0) ? '0
                  : w_dwell - FRAME_W'(1);
  assign w_expire = ~manual & (r_cnt >= w_lim_m1);

  assign w_decide = w_tick & (r_state == SHOW)
                  & (w_expire | r_skip);

  assign w_sel_nxt =
    (r_sel == SEL_W'(NUM_PATTERNS - 1)) ? '0
    : r_sel + SEL_W'(1);

  // animation strobe goes only to the active generator
  always_comb begin
    next_frame = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      next_frame[i] = w_tick & (r_sel == SEL_W'(i));
    end
  end

  // vsync history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vsync_q <= 1'b1;
    else        r_vsync_q <= vsync;
  end

  // sequencing FSM: dwell counting, skips and fades
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SHOW;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_atten <= '0;
      r_swp   <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_swp  <= 1'b0;
      r_skip <= skip_req | (r_skip & ~w_decide);
      if (w_tick) begin
        unique case (r_state)
          SHOW: begin
            if (w_expire | r_skip) begin
              if (fade_en) begin
                r_atten <= ATTEN_W'(1);
                r_state <= FADE_OUT;
              end else begin
                r_sel <= w_sel_nxt;
                r_cnt <= '0;
                r_swp <= 1'b1;
              end
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + FRAME_W'(1);
            end
          end
          FADE_OUT: begin
            if (r_atten < ATTEN_W'(ATTEN_MAX)) begin
              r_atten <= r_atten + ATTEN_W'(1);
            end else begin
              r_sel   <= w_sel_nxt;
              r_swp   <= 1'b1;
              r_state <= FADE_IN;
            end
          end
          FADE_IN: begin
            if (r_atten > ATTEN_W'(1)) begin
              r_atten <= r_atten - ATTEN_W'(1);
            end else begin
              r_atten <= '0;
              r_cnt   <= '0;
              r_state <= SHOW;
            end
          end
          default: r_state <= SHOW;
        endcase
      end
    end
  end

  assign pattern_select = r_sel;
  assign switch_pulse   = r_swp;

  rgb_attenuator u_atten (
    .i_px    (w_px),
    .i_shift (r_atten),
    .o_px    (rgb)
  );

endmodule
